// File: rtl/comparator_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_seq_if
//  Description : Request/response bundle for the multi-cycle magnitude
//                comparator. The requester (master) drives the operands,
//                compare mode and start strobe; the comparator (slave)
//                returns the handshake status and the six relation flags.
//
//  Signals
//    start        master -> slave  request a compare (sampled in IDLE only)
//    signed_mode  master -> slave  1 = two's-complement, 0 = unsigned
//    A, B         master -> slave  WIDTH-bit operands
//    busy         slave -> master  compare in progress
//    done         slave -> master  one-cycle pulse, flags just updated
//    flags_vld    slave -> master  at least one compare completed since reset
//    eq .. le     slave -> master  registered relation of A to B
//
//  Revision    : 1.0  initial release
// ============================================================================
interface comparator_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             flags_vld;
    logic             eq;
    logic             ne;
    logic             gt;
    logic             ge;
    logic             lt;
    logic             le;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, flags_vld, eq, ne, gt, ge, lt, le
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, flags_vld, eq, ne, gt, ge, lt, le
    );
endinterface
`default_nettype wire

// File: rtl/comparator_seq.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_seq
//  Description : Parametrised multi-cycle magnitude comparator. The operands
//                are captured on start and compared CHUNK bits per clock,
//                most-significant chunk first. The compare terminates on the
//                first unequal chunk, or on the last chunk if all are equal.
//                Signed and unsigned compares are supported.
//
//  Ports
//    clk    input  system clock, rising edge
//    rst_n  input  asynchronous active-low reset
//    bus    slave  comparator_seq_if (start/signed_mode/A/B in,
//                  busy/done/flags_vld/eq/ne/gt/ge/lt/le out)
//
//  Latency     : m cycles after the start edge, m = chunks examined
//                (1 .. WIDTH/CHUNK)
//  Revision    : 1.0  initial release
// ============================================================================
module comparator_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    comparator_seq_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IDX_W-1:0] c_IDX_TOP = IDX_W'(NCHUNK - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_BOT = '0;

    // Sign-bit mask: in signed mode only the operand MSB is flipped.
    localparam logic [WIDTH-1:0] c_SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_CMP  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_idx;
    logic             r_done;
    logic             r_flags_vld;
    logic             r_eq;
    logic             r_ne;
    logic             r_gt;
    logic             r_ge;
    logic             r_lt;
    logic             r_le;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [CHUNK-1:0] w_a_chunks [NCHUNK];
    logic [CHUNK-1:0] w_b_chunks [NCHUNK];
    logic [CHUNK-1:0] w_a_cur;
    logic [CHUNK-1:0] w_b_cur;
    logic             w_chunk_ne;
    logic             w_a_gt;
    logic             w_last_chunk;

    logic             w_busy;
    logic             w_capture;
    logic             w_finish;
    logic             w_eq_nxt;
    logic             w_gt_nxt;
    logic             w_lt_nxt;

    // ------------------------------------------------------------------------
    // Chunk slicing of the captured operands
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign w_a_chunks[gi] = r_a[gi*CHUNK +: CHUNK];
            assign w_b_chunks[gi] = r_b[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign w_a_cur      = w_a_chunks[r_idx];
    assign w_b_cur      = w_b_chunks[r_idx];
    assign w_chunk_ne   = (w_a_cur != w_b_cur);
    assign w_a_gt       = (w_a_cur >  w_b_cur);
    assign w_last_chunk = (r_idx == c_IDX_BOT);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = c_ST_CMP;
                end
            end
            c_ST_CMP: begin
                if (w_chunk_ne || w_last_chunk) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy    = 1'b0;
        w_capture = 1'b0;
        w_finish  = 1'b0;
        w_eq_nxt  = 1'b0;
        w_gt_nxt  = 1'b0;
        w_lt_nxt  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // start during CMP never reaches here, so it is ignored
                w_capture = bus.start;
            end
            c_ST_CMP: begin
                w_busy   = 1'b1;
                w_finish = w_chunk_ne || w_last_chunk;
                w_eq_nxt = !w_chunk_ne;
                w_gt_nxt = w_chunk_ne &&  w_a_gt;
                w_lt_nxt = w_chunk_ne && !w_a_gt;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand capture and chunk index
    // ------------------------------------------------------------------------
    // In signed mode the MSB of both operands is inverted at capture time.
    // This maps two's-complement onto offset binary, so the plain unsigned
    // chunk compare below orders signed values correctly. Only the top chunk
    // is affected; the lower chunks are compared unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
        end else if (w_capture) begin
            r_a   <= bus.signed_mode ? (bus.A ^ c_SIGN_MASK) : bus.A;
            r_b   <= bus.signed_mode ? (bus.B ^ c_SIGN_MASK) : bus.B;
            r_idx <= c_IDX_TOP;
        end else if (w_busy && !w_finish) begin
            r_idx <= r_idx - c_IDX_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Result flags and done pulse
    // ------------------------------------------------------------------------
    // Flags only change on completion, so a new capture in the done cycle
    // leaves the just-reported result visible until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done      <= 1'b0;
            r_flags_vld <= 1'b0;
            r_eq        <= 1'b0;
            r_ne        <= 1'b0;
            r_gt        <= 1'b0;
            r_ge        <= 1'b0;
            r_lt        <= 1'b0;
            r_le        <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_flags_vld <= 1'b1;
                r_eq        <= w_eq_nxt;
                r_ne        <= !w_eq_nxt;
                r_gt        <= w_gt_nxt;
                r_ge        <= w_gt_nxt || w_eq_nxt;
                r_lt        <= w_lt_nxt;
                r_le        <= w_lt_nxt || w_eq_nxt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.flags_vld = r_flags_vld;
    assign bus.eq        = r_eq;
    assign bus.ne        = r_ne;
    assign bus.gt        = r_gt;
    assign bus.ge        = r_ge;
    assign bus.lt        = r_lt;
    assign bus.le        = r_le;

endmodule
`default_nettype wire
